instruction_executor: RTL and testbench

- Parametrised successor to the team's channel-select instruction decoder.
- Accepts an instruction word over a valid/ready handshake. The word selects a source input channel, a destination output register and an opcode.
- Executes the opcode against a held bank of output registers. Multi-cycle ops (MUL) occupy a small FSM.
- Sits between the instruction source and downstream consumers of the output bank.

---
 rtl/instruction_executor_if.sv | 27 ++
 rtl/instruction_executor.sv | 197 +++++++++++++++++++
 tb/tb_instruction_executor.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_executor_if.sv
// Instruction handshake and output-bank bundle for instruction_executor.
// The source drives the master side, the executor implements the slave side.
interface instruction_executor_if #(
    parameter int NCH  = 8,
    parameter int W    = 4,
    parameter int SELW = $clog2(NCH),
    parameter int IW   = 2*SELW + 3
);
    logic [NCH-1:0][W-1:0] inp;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [IW-1:0]         instruct;
    logic [NCH-1:0][W-1:0] out;
    logic                  busy;
    logic                  done;
    logic                  ovf;

    modport master (
        output inp, instr_valid, instruct,
        input  instr_ready, out, busy, done, ovf
    );

    modport slave (
        input  inp, instr_valid, instruct,
        output instr_ready, out, busy, done, ovf
    );
endinterface

// File: rtl/instruction_executor.sv
// Executes src/dst/opcode instructions against a held bank of output registers;
// MUL runs as a W-cycle shift-add. Define INSTRUCTION_EXECUTOR_SAT_EN for saturating arithmetic.
module instruction_executor #(
    parameter int NCH  = 8,
    parameter int W    = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instruction_executor_if.slave  bus
);
    localparam int IW   = 2*SELW + 3;
    localparam int CNTW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MOV   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_CLR   = 3'd4;
    localparam logic [2:0] OP_MUL   = 3'd5;
    localparam logic [2:0] OP_SHL   = 3'd6;
    localparam logic [2:0] OP_LDALL = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t                r_state;
    logic [2:0]            r_op;
    logic [SELW-1:0]       r_dst;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;
    logic [NCH-1:0][W-1:0] r_snap;
    logic [NCH-1:0][W-1:0] r_out;
    logic [2*W-1:0]        r_acc;
    logic [2*W-1:0]        r_mcand;
    logic [W-1:0]          r_mplier;
    logic [CNTW-1:0]       r_cnt;
    logic                  r_done;
    logic                  r_ovf;

    logic [SELW-1:0]       w_src;
    logic [SELW-1:0]       w_dst;
    logic [2:0]            w_op;
    logic                  w_inRange;
    logic                  w_accept;
    logic [W-1:0]          w_a;
    logic [W-1:0]          w_b;
    logic [W:0]            w_sum;
    logic [W:0]            w_diff;
    logic [2*W-1:0]        w_accNext;
    logic                  w_mulLast;
    logic [W-1:0]          w_res;
    logic                  w_resOvf;
    logic                  w_wr;
    logic                  w_ldall;

    assign w_src     = bus.instruct[SELW-1:0];
    assign w_dst     = bus.instruct[2*SELW-1:SELW];
    assign w_op      = bus.instruct[IW-1:IW-3];
    assign w_inRange = (int'(w_src) < NCH) && (int'(w_dst) < NCH);
    assign w_accept  = bus.instr_valid && (r_state == IDLE);

    // Operand fetch by explicit compare so an out-of-range select reads zero instead of X.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_src == SELW'(i)) w_a = bus.inp[i];
            if (w_dst == SELW'(i)) w_b = r_out[i];
        end
    end

    assign w_sum     = {1'b0, r_b} + {1'b0, r_a};
    assign w_diff    = {1'b0, r_b} - {1'b0, r_a};
    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mulLast = (r_cnt == CNTW'(W-1));

    always_comb begin
        w_res    = '0;
        w_resOvf = 1'b0;
        w_wr     = 1'b0;
        w_ldall  = 1'b0;
        case (r_op)
            OP_MOV: begin
                w_res = r_a;
                w_wr  = 1'b1;
            end
            OP_ADD: begin
                w_res    = w_sum[W-1:0];
                w_resOvf = w_sum[W];
                w_wr     = 1'b1;
`ifdef INSTRUCTION_EXECUTOR_SAT_EN
                if (w_sum[W]) w_res = '1;
`endif
            end
            OP_SUB: begin
                w_res    = w_diff[W-1:0];
                w_resOvf = w_diff[W];
                w_wr     = 1'b1;
`ifdef INSTRUCTION_EXECUTOR_SAT_EN
                if (w_diff[W]) w_res = '0;
`endif
            end
            OP_CLR: begin
                w_wr = 1'b1;
            end
            OP_MUL: begin
                w_res    = w_accNext[W-1:0];
                w_resOvf = |w_accNext[2*W-1:W];
                w_wr     = 1'b1;
`ifdef INSTRUCTION_EXECUTOR_SAT_EN
                if (|w_accNext[2*W-1:W]) w_res = '1;
`endif
            end
            OP_SHL: begin
                w_res    = r_b << 1;
                w_resOvf = r_b[W-1];
                w_wr     = 1'b1;
`ifdef INSTRUCTION_EXECUTOR_SAT_EN
                if (r_b[W-1]) w_res = '1;
`endif
            end
            OP_LDALL: begin
                w_ldall = 1'b1;
            end
            default: begin
                w_wr = 1'b0;
            end
        endcase
    end

    // Operands are frozen at accept so later inp/out changes cannot disturb the op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_NOP;
            r_dst    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_snap   <= '0;
            r_out    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_inRange ? w_op : OP_NOP;
                        r_dst    <= w_dst;
                        r_a      <= w_a;
                        r_b      <= w_b;
                        r_snap   <= bus.inp;
                        r_acc    <= '0;
                        r_mcand  <= {{W{1'b0}}, w_b};
                        r_mplier <= w_a;
                        r_cnt    <= '0;
                        r_state  <= (w_inRange && (w_op == OP_MUL)) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (w_wr && (r_dst == SELW'(i))) r_out[i] <= w_res;
                    end
                    if (w_ldall) r_out <= r_snap;
                    r_ovf   <= w_resOvf;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mulLast) begin
                        for (int i = 0; i < NCH; i++) begin
                            if (r_dst == SELW'(i)) r_out[i] <= w_res;
                        end
                        r_ovf   <= w_resOvf;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (r_state == IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.ovf         = r_ovf;
    assign bus.out         = r_out;
endmodule

// File: tb/tb_instruction_executor.sv
// Directed-vector bench for instruction_executor: a table of instructions with hand-computed
// results, plus sequences for async reset, reset during MUL and back-to-back issue.
module tb_instruction_executor;
    localparam int NCH  = 8;
    localparam int W    = 4;
    localparam int SELW = $clog2(NCH);

    typedef struct {
        string      name;
        logic [2:0] op;
        int         src;
        int         dst;
        logic [W-1:0] srcVal;
        logic [W-1:0] expWrap;
        logic [W-1:0] expSat;
        logic       expOvf;
        int         lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   applied     = 0;
    int   miscompares = 0;
    vec_t vecs[$];
    logic [NCH-1:0][W-1:0] expBank;

    always #5 clk = ~clk;

    instruction_executor_if #(.NCH(NCH), .W(W)) bus ();

    instruction_executor #(.NCH(NCH), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic vec_t mkVec(string name, logic [2:0] op, int src, int dst,
                                   logic [W-1:0] srcVal, logic [W-1:0] expWrap,
                                   logic [W-1:0] expSat, logic expOvf, int lat);
        vec_t v;
        v.name = name; v.op = op; v.src = src; v.dst = dst; v.srcVal = srcVal;
        v.expWrap = expWrap; v.expSat = expSat; v.expOvf = expOvf; v.lat = lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH-1:0][W-1:0] stimInputs(int src, logic [W-1:0] val);
        logic [NCH-1:0][W-1:0] s;
        for (int i = 0; i < NCH; i++) s[i] = W'(i + 1);
        s[src] = val;
        return s;
    endfunction

    // Issue one instruction, then measure retirement latency and ready-low cycles.
    task automatic applyStimulus(input vec_t v);
        int guard = 0;
        int lat = 0;
        int readyLow = 0;
        logic [NCH-1:0][W-1:0] stim;
        @(negedge clk);
        while (bus.instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({v.name, " ready timeout"}, 64'(guard >= 20), 64'd0);
        stim = stimInputs(v.src, v.srcVal);
        bus.inp         = stim;
        bus.instruct    = {v.op, SELW'(v.dst), SELW'(v.src)};
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.inp         = ~stim;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.instr_ready !== 1'b1) readyLow++;
            if (bus.done === 1'b1) break;
        end
        if (v.op == 3'd7) begin
            expBank = stim;
        end else if (v.op != 3'd0) begin
`ifdef INSTRUCTION_EXECUTOR_SAT_EN
            expBank[v.dst] = v.expSat;
`else
            expBank[v.dst] = v.expWrap;
`endif
        end
        checkOutput({v.name, " latency"}, 64'(lat), 64'(v.lat));
        checkOutput({v.name, " ready-low cycles"}, 64'(readyLow), 64'(v.lat - 1));
        checkOutput({v.name, " bank"}, 64'(bus.out), 64'(expBank));
        checkOutput({v.name, " ovf"}, 64'(bus.ovf), 64'(v.expOvf));
        @(negedge clk);
        checkOutput({v.name, " done width"}, 64'(bus.done), 64'd0);
        checkOutput({v.name, " ovf hold"}, 64'(bus.ovf), 64'(v.expOvf));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instruct    = '0;
        bus.inp         = '0;
        expBank         = '0;

        //             name      op    src dst srcV wrap  sat  ovf lat
        vecs.push_back(mkVec("MOV",      3'd1, 4, 6, 4'd7,  4'd7,  4'd7,  1'b0, 2));
        vecs.push_back(mkVec("ADD ovf",  3'd2, 4, 6, 4'd9,  4'd0,  4'd15, 1'b1, 2));
        vecs.push_back(mkVec("SUB brw",  3'd3, 4, 3, 4'd13, 4'd3,  4'd0,  1'b1, 2));
        vecs.push_back(mkVec("MOV 3",    3'd1, 1, 2, 4'd3,  4'd3,  4'd3,  1'b0, 2));
        vecs.push_back(mkVec("MUL 3x5",  3'd5, 1, 2, 4'd5,  4'd15, 4'd15, 1'b0, 5));
        vecs.push_back(mkVec("CLR",      3'd4, 0, 2, 4'd1,  4'd0,  4'd0,  1'b0, 2));
        vecs.push_back(mkVec("MOV 4",    3'd1, 0, 2, 4'd4,  4'd4,  4'd4,  1'b0, 2));
        vecs.push_back(mkVec("MUL 4x5",  3'd5, 1, 2, 4'd5,  4'd4,  4'd15, 1'b1, 5));
        vecs.push_back(mkVec("MOV 12",   3'd1, 5, 6, 4'd12, 4'd12, 4'd12, 1'b0, 2));
        vecs.push_back(mkVec("SHL",      3'd6, 0, 6, 4'd1,  4'd8,  4'd15, 1'b1, 2));
        vecs.push_back(mkVec("ADD",      3'd2, 7, 5, 4'd6,  4'd6,  4'd6,  1'b0, 2));
        vecs.push_back(mkVec("ADD s=d",  3'd2, 5, 5, 4'd10, 4'd0,  4'd15, 1'b1, 2));
        vecs.push_back(mkVec("NOP",      3'd0, 3, 4, 4'd2,  4'd0,  4'd0,  1'b0, 2));
        vecs.push_back(mkVec("SUB zero", 3'd3, 0, 1, 4'd0,  4'd0,  4'd0,  1'b0, 2));
        vecs.push_back(mkVec("LDALL",    3'd7, 0, 0, 4'd1,  4'd0,  4'd0,  1'b0, 2));
        vecs.push_back(mkVec("MUL s=d",  3'd5, 3, 3, 4'd3,  4'd12, 4'd12, 1'b0, 5));
        vecs.push_back(mkVec("SUB",      3'd3, 2, 7, 4'd5,  4'd3,  4'd3,  1'b0, 2));

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset out",   64'(bus.out),         64'd0);
        checkOutput("reset ready", 64'(bus.instr_ready), 64'd1);
        checkOutput("reset busy",  64'(bus.busy),        64'd0);
        checkOutput("reset done",  64'(bus.done),        64'd0);
        checkOutput("reset ovf",   64'(bus.ovf),         64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) applyStimulus(vecs[k]);

        // Back-to-back: MOV held valid, CLR queued right behind it
        @(negedge clk);
        bus.inp         = stimInputs(6, 4'd9);
        bus.instruct    = {3'd1, SELW'(4), SELW'(6)};
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instruct    = {3'd4, SELW'(4), SELW'(0)};
        bus.inp         = '0;
        @(negedge clk);
        checkOutput("b2b ready low", 64'(bus.instr_ready), 64'd0);
        @(negedge clk);
        expBank[4] = 4'd9;
        checkOutput("b2b MOV done",  64'(bus.done),        64'd1);
        checkOutput("b2b MOV bank",  64'(bus.out),         64'(expBank));
        checkOutput("b2b ready",     64'(bus.instr_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b CLR busy",  64'(bus.busy), 64'd1);
        checkOutput("b2b CLR done0", 64'(bus.done), 64'd0);
        @(negedge clk);
        expBank[4] = 4'd0;
        checkOutput("b2b CLR done",  64'(bus.done), 64'd1);
        checkOutput("b2b CLR bank",  64'(bus.out),  64'(expBank));

        // Mid-cycle async reset with a populated bank
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expBank = '0;
        checkOutput("midreset out",   64'(bus.out),         64'd0);
        checkOutput("midreset ready", 64'(bus.instr_ready), 64'd1);
        checkOutput("midreset ovf",   64'(bus.ovf),         64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during MUL cycle 2 discards the multiply
        applyStimulus(mkVec("pre-MUL MOV", 3'd1, 1, 2, 4'd3, 4'd3, 4'd3, 1'b0, 2));
        @(negedge clk);
        bus.inp         = stimInputs(1, 4'd5);
        bus.instruct    = {3'd5, SELW'(2), SELW'(1)};
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mulrst busy before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mulrst busy",  64'(bus.busy),        64'd0);
        checkOutput("mulrst ready", 64'(bus.instr_ready), 64'd1);
        checkOutput("mulrst out",   64'(bus.out),         64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int doneSeen = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.done === 1'b1) doneSeen++;
            end
            checkOutput("mulrst no done", 64'(doneSeen), 64'd0);
        end
        checkOutput("mulrst out after", 64'(bus.out),  64'd0);
        checkOutput("mulrst idle",      64'(bus.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
